// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch path.
//   seq_op_t     : sequencing op encoding used by decode and pc_sequencer
//   PC_W_DEFAULT : default program-counter / instruction-address width
package cpu_pkg;

  localparam int PC_W_DEFAULT = 11;

  // Codes 6 and 7 are reserved and are treated as OP_NEXT by the sequencer.
  typedef enum logic [2:0] {
    OP_NEXT = 3'd0,
    OP_JUMP = 3'd1,
    OP_SKIP = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_HOLD = 3'd5
  } seq_op_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode/divider-to-sequencer bundle.
//   master : decode side (drives en, op, target, skip_cond, clr_flags;
//            observes pc, stack status and sticky flags)
//   slave  : pc_sequencer side
// Handshake: there is no valid/ready pair. en is the only qualifier; an op is
// consumed on every rising clk edge where en=1 and ignored when en=0.
interface pc_sequencer_if
  import cpu_pkg::*;
#(
  parameter int PC_W        = PC_W_DEFAULT,
  parameter int STACK_DEPTH = 8
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic             en;
  logic [2:0]       op;
  logic [PC_W-1:0]  target;
  logic             skip_cond;
  logic             clr_flags;
  logic [PC_W-1:0]  pc;
  logic [LVL_W-1:0] stack_lvl;
  logic             stack_full;
  logic             stack_empty;
  logic             ovf;
  logic             unf;

  modport master (
    output en, op, target, skip_cond, clr_flags,
    input  pc, stack_lvl, stack_full, stack_empty, ovf, unf
  );

  modport slave (
    input  en, op, target, skip_cond, clr_flags,
    output pc, stack_lvl, stack_full, stack_empty, ovf, unf
  );

endinterface

// File: rtl/pc_stack.sv
// Circular LIFO holding return addresses.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   push, din  : write din at sp, advance sp (overwrites oldest when full)
//   pop        : retreat sp (ignored when empty)
//   dout       : current top, mem[sp-1]
//   lvl        : number of valid entries, saturates at DEPTH
//   full/empty : decodes of lvl
// Memory contents are not cleared by reset; only sp and lvl are.
module pc_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 11
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] lvl,
  output logic                       full,
  output logic                       empty
);
  localparam int SP_W  = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [W-1:0]    mem [DEPTH];
  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_inc;
  logic [SP_W-1:0] sp_dec;

  // Explicit wrap so non-power-of-two depths stay inside the buffer.
  assign sp_inc = (sp == SP_W'(DEPTH - 1)) ? '0 : sp + SP_W'(1);
  assign sp_dec = (sp == '0) ? SP_W'(DEPTH - 1) : sp - SP_W'(1);

  assign dout  = mem[sp_dec];
  assign full  = (lvl == LVL_W'(DEPTH));
  assign empty = (lvl == '0);

  always_ff @(posedge clk) begin
    if (!reset && push) mem[sp] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp  <= '0;
      lvl <= '0;
    end else if (push) begin
      sp <= sp_inc;
      if (!full) lvl <= lvl + LVL_W'(1);
    end else if (pop && !empty) begin
      sp  <= sp_dec;
      lvl <= lvl - LVL_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch path.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : pc_sequencer_if.slave (en/op/target/skip_cond/clr_flags in;
//                pc/stack_lvl/stack_full/stack_empty/ovf/unf out)
// Holds the pc register, the next-pc mux and the sticky ovf/unf flags; the
// return stack lives in pc_stack. All PC arithmetic wraps modulo 2^PC_W.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W        = PC_W_DEFAULT,
  parameter int              STACK_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_VEC   = '0
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_d;
  logic [PC_W-1:0]  pc_inc1;
  logic [PC_W-1:0]  pc_inc2;
  logic             push;
  logic             pop;
  logic             call_full;
  logic             ret_empty;
  logic [PC_W-1:0]  stk_dout;
  logic [LVL_W-1:0] stk_lvl;
  logic             stk_full;
  logic             stk_empty;
  logic             ovf_q;
  logic             unf_q;

  assign pc_inc1 = pc_q + PC_W'(1);
  assign pc_inc2 = pc_q + PC_W'(2);

  always_comb begin
    pc_d      = pc_q;
    push      = 1'b0;
    pop       = 1'b0;
    call_full = 1'b0;
    ret_empty = 1'b0;
    if (bus.en) begin
      case (bus.op)
        OP_JUMP: pc_d = bus.target;
        OP_SKIP: pc_d = bus.skip_cond ? pc_inc2 : pc_inc1;
        OP_CALL: begin
          push      = 1'b1;
          call_full = stk_full;
          pc_d      = bus.target;
        end
        OP_RET: begin
          // An empty stack has no return address: restart at the reset vector.
          if (stk_empty) begin
            ret_empty = 1'b1;
            pc_d      = RESET_VEC;
          end else begin
            pop  = 1'b1;
            pc_d = stk_dout;
          end
        end
        OP_HOLD: pc_d = pc_q;
        default: pc_d = pc_inc1;  // OP_NEXT and reserved codes
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_VEC;
    else       pc_q <= pc_d;
  end

  // Sticky flags: a new event in the same cycle as clr_flags keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (call_full)          ovf_q <= 1'b1;
      else if (bus.clr_flags) ovf_q <= 1'b0;
      if (ret_empty)          unf_q <= 1'b1;
      else if (bus.clr_flags) unf_q <= 1'b0;
    end
  end

  pc_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc1),
    .dout  (stk_dout),
    .lvl   (stk_lvl),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign bus.pc          = pc_q;
  assign bus.stack_lvl   = stk_lvl;
  assign bus.stack_full  = stk_full;
  assign bus.stack_empty = stk_empty;
  assign bus.ovf         = ovf_q;
  assign bus.unf         = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by randomized ops,
// every cycle compared against a queue-based reference model.
module tb_pc_sequencer;
  import cpu_pkg::*;

  localparam int PC_W        = 11;
  localparam int STACK_DEPTH = 8;
  localparam int RV          = 0;
  localparam int MODV        = 1 << PC_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_W(PC_W), .STACK_DEPTH(STACK_DEPTH)) bif ();

  pc_sequencer #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH),
    .RESET_VEC   (PC_W'(RV))
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int m_pc  = 0;
  int exp_q[$];      // return addresses, newest at the back
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: advance one clock edge from the specification's rules.
  task automatic model_step(input bit e, input int o, input int t, input bit sc,
                            input bit clr, input bit rst);
    bit set_o, set_u;
    set_o = 1'b0;
    set_u = 1'b0;
    if (rst) begin
      m_pc  = RV;
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (e) begin
        case (o)
          1: m_pc = t;
          2: m_pc = (m_pc + (sc ? 2 : 1)) % MODV;
          3: begin
            exp_q.push_back((m_pc + 1) % MODV);
            if (exp_q.size() > STACK_DEPTH) begin
              void'(exp_q.pop_front());
              set_o = 1'b1;
            end
            m_pc = t;
          end
          4: begin
            if (exp_q.size() == 0) begin
              m_pc  = RV;
              set_u = 1'b1;
            end else begin
              m_pc = exp_q.pop_back();
            end
          end
          5: ;
          default: m_pc = (m_pc + 1) % MODV;
        endcase
      end
      if (set_o)    m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (set_u)    m_unf = 1'b1;
      else if (clr) m_unf = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit e, input int o, input int t, input bit sc,
                      input bit clr, input bit rst);
    bif.en        = e;
    bif.op        = 3'(o);
    bif.target    = PC_W'(t);
    bif.skip_cond = sc;
    bif.clr_flags = clr;
    reset         = rst;
    @(posedge clk);
    model_step(e, o, t, sc, clr, rst);
    #1;
    check("pc",          32'(bif.pc),          32'(m_pc));
    check("stack_lvl",   32'(bif.stack_lvl),   32'(exp_q.size()));
    check("stack_full",  32'(bif.stack_full),  32'(exp_q.size() == STACK_DEPTH));
    check("stack_empty", 32'(bif.stack_empty), 32'(exp_q.size() == 0));
    check("ovf",         32'(bif.ovf),         32'(m_ovf));
    check("unf",         32'(bif.unf),         32'(m_unf));
  endtask

  task automatic op1(input int o, input int t = 0, input bit sc = 1'b0, input bit clr = 1'b0);
    step(1'b1, o, t, sc, clr, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bif.en = 1'b0; bif.op = '0; bif.target = '0; bif.skip_cond = 1'b0;
    bif.clr_flags = 1'b0; reset = 1'b1;

    // Reset, counting, stall
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 0, 0, 1'b0, 1'b0, 1'b1);
    repeat (4) op1(0);
    repeat (3) step(1'b0, 0, 123, 1'b1, 1'b0, 1'b0);
    check("pc_after_stall", 32'(bif.pc), 32'd4);

    // Wraparound
    op1(1, MODV - 1);
    op1(0);
    check("wrap_next", 32'(bif.pc), 32'd0);
    op1(1, MODV - 2);
    op1(2, 0, 1'b1);
    check("wrap_skip", 32'(bif.pc), 32'd0);
    op1(1, 5);
    op1(2, 0, 1'b0);
    check("skip_not_taken", 32'(bif.pc), 32'd6);

    // Call / return
    op1(1, 10);
    op1(3, 40);
    op1(0);
    op1(4);
    check("ret_addr", 32'(bif.pc), 32'd11);

    // Overflow then drain, underflow
    for (int i = 0; i < 9; i++) op1(3, 100 + i * 10);
    check("ovf_after_9", 32'(bif.ovf), 32'd1);
    step(1'b0, 3, 0, 1'b0, 1'b1, 1'b0);  // clr_flags with no event, stalled
    check("ovf_cleared", 32'(bif.ovf), 32'd0);
    for (int i = 0; i < 9; i++) op1(4);
    check("unf_after_9th", 32'(bif.unf), 32'd1);
    op1(5, 0, 1'b0, 1'b1);  // HOLD + clr
    check("unf_cleared", 32'(bif.unf), 32'd0);

    // Reset beats a CALL on a full stack
    for (int i = 0; i < 9; i++) op1(3, 300 + i);
    step(1'b1, 3, 77, 1'b0, 1'b0, 1'b1);
    check("call_reset_ovf", 32'(bif.ovf), 32'd0);

    // Reserved ops, RET on empty with clr
    op1(1, 20);
    op1(6);
    op1(7);
    check("reserved_next", 32'(bif.pc), 32'd22);
    op1(4, 0, 1'b0, 1'b1);
    check("unf_wins_clr", 32'(bif.unf), 32'd1);

    // Randomized phase
    for (int n = 0; n < 600; n++) begin
      int o;
      o = $urandom_range(0, 7);
      if ($urandom_range(0, 2) == 0) o = ($urandom_range(0, 1) != 0) ? 3 : 4;
      step($urandom_range(0, 7) != 0, o, $urandom_range(0, MODV - 1),
           $urandom_range(0, 1) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 99) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
